// File: rtl/alu_logic_issue_rv32i.sv
// Issue/result stage for RV32I XOR/OR/AND and their immediate forms: selects operand B,
// maps funct3 to a gate code, evaluates and queues {result, tag, illegal} toward writeback.

module alu_logic_gate_unit (
    input  logic [2:0]  gate_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (gate_sel)
            3'b000:  y = a ^ b;
            3'b001:  y = a | b;
            3'b010:  y = a & b;
            default: y = '0;
        endcase
    end
endmodule

module alu_logic_issue_rv32i #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_use_imm,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [11:0]      in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [31:0]      op_count
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and in_ready depends on the fill level only.
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [31:0]      mem_result  [2];
    logic [TAG_W-1:0] mem_tag     [2];
    logic             mem_illegal [2];

    logic             push;
    logic             pop;
    logic [2:0]       gate_sel;
    logic             illegal;
    logic [31:0]      op_b;
    logic [31:0]      gate_y;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign op_b      = in_use_imm ? {{20{in_imm[11]}}, in_imm} : in_rs2;

    always_comb begin
        gate_sel = 3'b011;
        illegal  = 1'b1;
        case (in_funct3)
            3'b100:  begin gate_sel = 3'b000; illegal = 1'b0; end
            3'b110:  begin gate_sel = 3'b001; illegal = 1'b0; end
            3'b111:  begin gate_sel = 3'b010; illegal = 1'b0; end
            default: begin gate_sel = 3'b011; illegal = 1'b1; end
        endcase
    end

    alu_logic_gate_unit u_gate (
        .gate_sel (gate_sel),
        .a        (in_rs1),
        .b        (op_b),
        .y        (gate_y)
    );

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_result[wr_ptr]  <= gate_y;
            mem_tag[wr_ptr]     <= in_tag;
            mem_illegal[wr_ptr] <= illegal;
        end
    end

    // out_* are a registered copy of the head so they hold the last popped entry once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= ~wr_ptr;
                op_count <= op_count + 32'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop && count == 2'd2) begin
                out_result  <= mem_result[~rd_ptr];
                out_tag     <= mem_tag[~rd_ptr];
                out_illegal <= mem_illegal[~rd_ptr];
            end else if (push && (count == 2'd0 || pop)) begin
                out_result  <= gate_y;
                out_tag     <= in_tag;
                out_illegal <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_alu_logic_issue_rv32i.sv
// Bench for alu_logic_issue_rv32i: directed vector table, hand-written backpressure/reset
// sequences and a randomized run against a queue-based reference model.

module tb_alu_logic_issue_rv32i;
    localparam int TAG_W = 5;
    localparam int W     = 32 + TAG_W + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_use_imm;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [11:0]      in_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [31:0]      op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  mdl_ops;

    typedef struct {
        logic [2:0]       funct3;
        logic             use_imm;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [11:0]      imm;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_result;
        logic             exp_illegal;
    } vec_t;

    vec_t vecs[8];

    alu_logic_issue_rv32i #(.TAG_W(TAG_W), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_use_imm  (in_use_imm),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // reference: architectural meaning of the logical ops
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic use_imm,
                                               input logic [31:0] a, input logic [31:0] rs2,
                                               input logic [11:0] imm);
        logic [31:0] b;
        b = use_imm ? 32'($signed(imm)) : rs2;
        case (f3)
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // driver tasks
    task automatic set_op(input logic [2:0] f3, input logic use_imm, input logic [31:0] a,
                          input logic [31:0] b, input logic [11:0] imm, input logic [TAG_W-1:0] tag);
        in_valid   = 1'b1;
        in_funct3  = f3;
        in_use_imm = use_imm;
        in_rs1     = a;
        in_rs2     = b;
        in_imm     = imm;
        in_tag     = tag;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_use_imm = 1'b0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;

        vecs[0] = '{3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 5'd5,  32'hFF00_FF00, 1'b0};
        vecs[1] = '{3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 5'd6,  32'hFFF0_FFF0, 1'b0};
        vecs[2] = '{3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 5'd7,  32'h00F0_00F0, 1'b0};
        vecs[3] = '{3'b111, 1'b1, 32'h1234_5678, 32'h0000_0000, 12'hFFF, 5'd8,  32'h1234_5678, 1'b0};
        vecs[4] = '{3'b100, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 12'h800, 5'd9,  32'hFFFF_F800, 1'b0};
        vecs[5] = '{3'b110, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 12'h7FF, 5'd10, 32'h0000_07FF, 1'b0};
        vecs[6] = '{3'b001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'h000, 5'd11, 32'h0000_0000, 1'b1};
        vecs[7] = '{3'b000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 12'hFFF, 5'd31, 32'h0000_0000, 1'b1};

        // reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op_count", op_count, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);

        // table: one op at a time with writeback always ready
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            set_op(vecs[i].funct3, vecs[i].use_imm, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].tag);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
            check($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            check($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_illegal));
            check($sformatf("vec%0d_op_count", i), op_count, 32'(i + 1));
            step();
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // OR then AND back-to-back: one result per cycle, in order
        do_reset();
        out_ready = 1'b1;
        set_op(3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h0, 5'd1);
        step();
        set_op(3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h0, 5'd2);
        check("b2b_first", out_result, 32'hFFF0_FFF0);
        check("b2b_first_tag", 32'(out_tag), 32'd1);
        step();
        in_valid = 1'b0;
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second", out_result, 32'h00F0_00F0);
        check("b2b_second_tag", 32'(out_tag), 32'd2);
        step();
        check("b2b_empty", 32'(out_valid), 32'd0);

        // backpressure: third op held while full, accepted the cycle after the first pop
        do_reset();
        out_ready = 1'b0;
        set_op(3'b100, 1'b0, 32'h0000_00AA, 32'h0000_00FF, 12'h0, 5'd1);
        check("bp_ready0", 32'(in_ready), 32'd1);
        step();
        set_op(3'b110, 1'b0, 32'h0000_0F00, 32'h0000_00F0, 12'h0, 5'd2);
        check("bp_ready1", 32'(in_ready), 32'd1);
        step();
        set_op(3'b111, 1'b1, 32'hABCD_1234, 32'h0, 12'h0FF, 5'd3);
        check("bp_full", 32'(in_ready), 32'd0);
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_head_stable", out_result, 32'h0000_0055);
        check("bp_count_held", op_count, 32'd2);
        out_ready = 1'b1;
        step();
        check("bp_slot_free", 32'(in_ready), 32'd1);
        check("bp_second_head", out_result, 32'h0000_0FF0);
        check("bp_second_tag", 32'(out_tag), 32'd2);
        check("bp_count_before_3rd", op_count, 32'd2);
        step();
        in_valid = 1'b0;
        check("bp_third_head", out_result, 32'h0000_0034);
        check("bp_third_tag", 32'(out_tag), 32'd3);
        check("bp_op_count", op_count, 32'd3);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // reset with two entries queued, upstream still pushing
        do_reset();
        out_ready = 1'b0;
        set_op(3'b100, 1'b0, 32'h1, 32'h2, 12'h0, 5'd4);
        step();
        step();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_op_count", op_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst_no_stale%0d", i), 32'(out_valid), 32'd0);
        end

        // randomized traffic against the queue model
        do_reset();
        exp_q.delete();
        mdl_ops = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       exp_rdy;
            logic [W-1:0] ent;
            logic [2:0]  f3;
            logic        ui;
            logic [31:0] a;
            logic [31:0] b;
            logic [11:0] imm;
            logic [TAG_W-1:0] tg;
            exp_rdy = (exp_q.size() < 2);
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            check("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("rnd_op_count", op_count, mdl_ops);
            if (exp_q.size() != 0) begin
                ent = exp_q[0];
                check("rnd_result", out_result, ent[W-1 -: 32]);
                check("rnd_tag", 32'(out_tag), 32'(ent[TAG_W:1]));
                check("rnd_illegal", 32'(out_illegal), 32'(ent[0]));
            end
            f3  = 3'($urandom_range(0, 7));
            ui  = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            imm = 12'($urandom);
            tg  = TAG_W'($urandom);
            set_op(f3, ui, a, b, imm, tg);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) begin
                exp_q.push_back({ref_result(f3, ui, a, b, imm), tg, !(f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7)});
                mdl_ops = mdl_ops + 32'd1;
            end
            step();
        end
        in_valid = 1'b0;

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
